tx_stream_mux: RTL



---
 rtl/tx_stream_mux.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tx_stream_mux.sv
`timescale 1ns/1ps
// tx_stream_mux
// Transmit-path stream multiplexer between the LTSSM-controlled sources and
// the PHY lane datapath. One of NSRC sources is forwarded to a registered
// LANES-byte output with ready/valid handshakes on both sides. A source change
// requested on sel_req is deferred until the current block has finished and
// the output register has drained, so no TLP, DLLP or ordered set is split.
//
// Build option:
//   TX_MUX_BLOCK_GUARD_EN  defined   : track src_last and defer switching
//                                      to block boundaries.
//                          undefined : src_last ignored; a switch starts on
//                                      the cycle after the request.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   sel_req       requested source index (values >= NSRC ignored)
//   src_data      source i at bits [i*LANES*8 +: LANES*8]
//   src_datak     per-byte K flag per source
//   src_valid     per-byte valid per source; beat present when any bit set
//   src_last      final beat of a block/packet per source
//   src_ready     beat accepted from source i when present and ready
//   out_data      registered output beat
//   out_datak     registered K flags
//   out_valid     registered per-byte valid; all zero = empty
//   out_ready     downstream accepts the current output beat
//   cur_sel       source currently forwarded
//   switch_done   one-cycle pulse when cur_sel changes
module tx_stream_mux #(
    parameter int LANES     = 8,
    parameter int NSRC      = 3,
    parameter int SELW      = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter int RESET_SEL = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [SELW-1:0]          sel_req,
    input  logic [NSRC*LANES*8-1:0]  src_data,
    input  logic [NSRC*LANES-1:0]    src_datak,
    input  logic [NSRC*LANES-1:0]    src_valid,
    input  logic [NSRC-1:0]          src_last,
    output logic [NSRC-1:0]          src_ready,
    output logic [LANES*8-1:0]       out_data,
    output logic [LANES-1:0]         out_datak,
    output logic [LANES-1:0]         out_valid,
    input  logic                     out_ready,
    output logic [SELW-1:0]          cur_sel,
    output logic                     switch_done
);

    localparam int DW = LANES * 8;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_DRAIN,
        ST_SWITCH
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DW-1:0]     r_out_data;
    logic [LANES-1:0]  r_out_datak;
    logic [LANES-1:0]  r_out_valid;
    logic [SELW-1:0]   r_cur_sel;
    logic              r_switch_done;
    logic              r_run;

    logic [DW-1:0]     w_src_data;
    logic [LANES-1:0]  w_src_datak;
    logic [LANES-1:0]  w_src_valid;
    logic              w_src_last;
    logic              w_in_block;
    logic              w_req_ok;
    logic              w_stop;
    logic              w_full;
    logic              w_can_load;
    logic              w_ready_cur;
    logic              w_xfer;

    // Selected-source view
    always_comb begin
        w_src_data  = '0;
        w_src_datak = '0;
        w_src_valid = '0;
        w_src_last  = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (SELW'(i) == r_cur_sel) begin
                w_src_data  = src_data[i*DW +: DW];
                w_src_datak = src_datak[i*LANES +: LANES];
                w_src_valid = src_valid[i*LANES +: LANES];
                w_src_last  = src_last[i];
            end
        end
    end

    assign w_req_ok   = (sel_req != r_cur_sel) && (32'(sel_req) < NSRC);
    // A pending request outside a block stops acceptance at once, so no new
    // block is started on the cycle the switch is decided.
    assign w_stop     = w_req_ok && !w_in_block;
    assign w_full     = |r_out_valid;
    assign w_can_load = !w_full || out_ready;
    // r_run keeps src_ready low until the first edge after reset release.
    assign w_ready_cur = (r_state == ST_ACTIVE) && r_run && w_can_load && !w_stop;
    assign w_xfer      = w_ready_cur && (|w_src_valid);

`ifdef TX_MUX_BLOCK_GUARD_EN
    logic r_in_block;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_block <= 1'b0;
        end else if (r_state == ST_SWITCH) begin
            r_in_block <= 1'b0;
        end else if (w_xfer) begin
            r_in_block <= !w_src_last;
        end
    end

    assign w_in_block = r_in_block;
`else
    logic w_unused_last;

    assign w_in_block    = 1'b0;
    assign w_unused_last = w_src_last;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_ACTIVE: begin
                // Leave once no block is open after this cycle's transfer.
                if (w_req_ok && (!w_in_block || (w_xfer && w_src_last))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_can_load) begin
                    w_state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_state_nxt = ST_ACTIVE;
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        src_ready = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src_ready[i] = w_ready_cur && (SELW'(i) == r_cur_sel);
        end
    end

    // Output register, selection and switch pulse.
    // cur_sel is committed on the DRAIN->SWITCH edge so that switch_done and
    // the new cur_sel are visible together during SWITCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data    <= '0;
            r_out_datak   <= '0;
            r_out_valid   <= '0;
            r_cur_sel     <= SELW'(RESET_SEL);
            r_switch_done <= 1'b0;
            r_run         <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_switch_done <= 1'b0;
            if (w_xfer) begin
                r_out_data  <= w_src_data;
                r_out_datak <= w_src_datak;
                r_out_valid <= w_src_valid;
            end else if (out_ready) begin
                r_out_valid <= '0;
            end
            if ((r_state == ST_DRAIN) && w_can_load && w_req_ok) begin
                r_cur_sel     <= sel_req;
                r_switch_done <= 1'b1;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_datak   = r_out_datak;
    assign out_valid   = r_out_valid;
    assign cur_sel     = r_cur_sel;
    assign switch_done = r_switch_done;

endmodule
